// File: rtl/clock_monitor.sv
// Measures high time, low time and period of an asynchronous slow clock in
// master-clock cycles; flags loss of clock and lock on consecutive periods.
module clock_monitor #(
  parameter int unsigned LEN     = 26,
  parameter int unsigned TIMEOUT = 50000000,
  parameter int unsigned TOL     = 2,
  parameter int unsigned SYNC    = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clkin,
  output logic [LEN-1:0] half_hi,
  output logic [LEN-1:0] half_lo,
  output logic [LEN:0]   period,
  output logic           valid,
  output logic           locked,
  output logic           lost
);

  typedef enum logic [1:0] {SEARCH, MEAS_HI, MEAS_LO, LOST} state_t;

  localparam logic [LEN-1:0] CTR_MAX = LEN'(TIMEOUT - 1);
  localparam logic [LEN:0]   TOL_W   = (LEN + 1)'(TOL);

  state_t          state, state_nxt;
  logic [SYNC-1:0] sync_q;
  logic [SYNC:0]   fill_q;
  logic            lvl_d;
  logic            lvl, primed, rise, fall, edge_det, timeout;
  logic [LEN-1:0]  ctr, width, hi_q;
  logic            arm, arm_nxt;
  logic            capture_hi, capture_per, enter_lost, leave_lost;
  logic [LEN:0]    new_period, prev_period, diff;
  logic            have_prev;

  // Edges are masked until the synchronizer and edge flop hold real samples,
  // so reset-zeroed flops never fake a rising edge when clkin starts high.
  assign primed   = fill_q[SYNC];
  assign lvl      = sync_q[SYNC-1];
  assign rise     = primed & lvl & ~lvl_d;
  assign fall     = primed & ~lvl & lvl_d;
  assign edge_det = rise | fall;
  assign timeout  = (ctr == CTR_MAX) && !edge_det;

  assign width      = ctr + 1'b1;
  assign new_period = {1'b0, hi_q} + {1'b0, width};
  assign diff       = (new_period >= prev_period) ? (new_period - prev_period)
                                                  : (prev_period - new_period);

  always_comb begin
    state_nxt   = state;
    arm_nxt     = arm;
    capture_hi  = 1'b0;
    capture_per = 1'b0;
    enter_lost  = 1'b0;
    leave_lost  = 1'b0;
    case (state)
      SEARCH: begin
        if (primed && !lvl) arm_nxt = 1'b1;
        if (rise && arm) begin
          state_nxt = MEAS_HI;
          arm_nxt   = 1'b0;
        end else if (timeout) begin
          state_nxt  = LOST;
          arm_nxt    = 1'b0;
          enter_lost = 1'b1;
        end
      end
      MEAS_HI: begin
        if (fall) begin
          capture_hi = 1'b1;
          state_nxt  = MEAS_LO;
        end else if (timeout) begin
          state_nxt  = LOST;
          enter_lost = 1'b1;
        end
      end
      MEAS_LO: begin
        if (rise) begin
          capture_per = 1'b1;
          state_nxt   = MEAS_HI;
        end else if (timeout) begin
          state_nxt  = LOST;
          enter_lost = 1'b1;
        end
      end
      LOST: begin
        if (fall) arm_nxt = 1'b1;
        if (rise && arm) begin
          state_nxt  = MEAS_HI;
          arm_nxt    = 1'b0;
          leave_lost = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SEARCH;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= '0;
      fill_q      <= '0;
      lvl_d       <= 1'b0;
      ctr         <= '0;
      arm         <= 1'b0;
      hi_q        <= '0;
      prev_period <= '0;
      have_prev   <= 1'b0;
      half_hi     <= '0;
      half_lo     <= '0;
      period      <= '0;
      valid       <= 1'b0;
      locked      <= 1'b0;
      lost        <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], clkin};
      fill_q <= {fill_q[SYNC-1:0], 1'b1};
      lvl_d  <= lvl;
      arm    <= arm_nxt;
      valid  <= capture_per;

      if (edge_det)            ctr <= '0;
      else if (ctr != CTR_MAX) ctr <= ctr + 1'b1;

      if (capture_hi) hi_q <= width;

      if (capture_per) begin
        half_hi     <= hi_q;
        half_lo     <= width;
        period      <= new_period;
        prev_period <= new_period;
        have_prev   <= 1'b1;
        if (have_prev) locked <= (diff <= TOL_W);
      end

      if (enter_lost) begin
        lost      <= 1'b1;
        locked    <= 1'b0;
        have_prev <= 1'b0;
      end
      if (leave_lost) lost <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Randomized bench for clock_monitor: a timestamp-based reference model
// predicts every output each cycle from the driven clkin history.
module tb_clock_monitor;

  localparam int unsigned LEN     = 10;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned TOL     = 2;
  localparam int unsigned SYNC    = 2;
  localparam int          LAT     = SYNC + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           clkin = 1'b1;
  logic [LEN-1:0] half_hi, half_lo;
  logic [LEN:0]   period;
  logic           valid, locked, lost;

  clock_monitor #(.LEN(LEN), .TIMEOUT(TIMEOUT), .TOL(TOL), .SYNC(SYNC)) dut (
    .clk(clk), .rst(rst), .clkin(clkin),
    .half_hi(half_hi), .half_lo(half_lo), .period(period),
    .valid(valid), .locked(locked), .lost(lost)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: modes WAIT / HI / LO / DEAD, widths from edge timestamps.
  localparam int WAIT = 0, HI = 1, LO = 2, DEAD = 3;
  logic hist[$];
  bit   run = 1'b0;
  int   n, last_edge, mode, hi_w, prev_per;
  bit   seen_fall, have;
  int   e_hi, e_lo, e_per;
  bit   e_valid, e_lost, e_locked;

  function automatic logic seen_at(input int k);
    int idx = k - LAT;
    if (idx < 0) idx = 0;
    return hist[idx];
  endfunction

  task automatic model_init();
    hist.delete();
    hist.push_back(clkin);
    n = 0; last_edge = 0; mode = WAIT; hi_w = 0; prev_per = 0;
    seen_fall = 0; have = 0;
    e_hi = 0; e_lo = 0; e_per = 0; e_valid = 0; e_lost = 0; e_locked = 0;
  endtask

  task automatic model_step();
    logic now_l, was_l;
    int w, d;
    n++;
    hist.push_back(clkin);
    now_l   = seen_at(n);
    was_l   = seen_at(n - 1);
    e_valid = 0;
    if (n > LAT && now_l != was_l) begin
      w = n - last_edge;
      last_edge = n;
      if (now_l) begin
        if (mode == WAIT) mode = HI;
        else if (mode == LO) begin
          e_valid = 1; e_hi = hi_w; e_lo = w; e_per = hi_w + w;
          if (have) begin
            d = e_per - prev_per;
            if (d < 0) d = -d;
            e_locked = (d <= int'(TOL));
          end
          prev_per = e_per; have = 1; mode = HI;
        end else if (mode == DEAD && seen_fall) begin
          mode = HI; e_lost = 0; seen_fall = 0;
        end
      end else begin
        if (mode == HI) begin hi_w = w; mode = LO; end
        else if (mode == DEAD) seen_fall = 1;
      end
    end else if (mode != DEAD && n - last_edge >= int'(TIMEOUT)) begin
      mode = DEAD; e_lost = 1; e_locked = 0; have = 0; seen_fall = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (run) begin
        model_step();
        check_eq("valid",   32'(valid),   32'(e_valid));
        check_eq("lost",    32'(lost),    32'(e_lost));
        check_eq("locked",  32'(locked),  32'(e_locked));
        check_eq("half_hi", 32'(half_hi), e_hi);
        check_eq("half_lo", 32'(half_lo), e_lo);
        check_eq("period",  32'(period),  e_per);
      end
    end
  end

  task automatic apply_reset(input logic lvl);
    @(posedge clk);
    run = 1'b0;
    #4 rst = 1'b0;
    #1;
    check_eq("rst_valid",   32'(valid),   0);
    check_eq("rst_lost",    32'(lost),    0);
    check_eq("rst_locked",  32'(locked),  0);
    check_eq("rst_half_hi", 32'(half_hi), 0);
    check_eq("rst_half_lo", 32'(half_lo), 0);
    check_eq("rst_period",  32'(period),  0);
    clkin = lvl;
    repeat (3) @(posedge clk);
    #5 rst = 1'b1;
    model_init();
    run = 1'b1;
  endtask

  task automatic seg(input logic lvl, input int unsigned cyc);
    @(posedge clk);
    #1 clkin = lvl;
    repeat (cyc - 1) @(posedge clk);
  endtask

  task automatic idle(input int unsigned cyc);
    repeat (cyc) @(posedge clk);
  endtask

  initial begin
    // Power-up with clkin high: nothing until timeout, then recovery.
    apply_reset(1'b1);
    idle(80);
    seg(0, 6); seg(1, 7); seg(0, 5); seg(1, 5);

    // 5/5 square wave, then 3/7 duty.
    for (int i = 0; i < 4; i++) begin seg(0, 5); seg(1, 5); end
    for (int i = 0; i < 3; i++) begin seg(0, 7); seg(1, 3); end

    // Periods 10, 12, 16.
    seg(0, 5); seg(1, 6); seg(0, 6); seg(1, 8); seg(0, 8); seg(1, 5);

    // Edge landing exactly on the last counter value, then one cycle too late.
    seg(0, TIMEOUT); seg(1, TIMEOUT); seg(0, 5); seg(1, 5);
    seg(0, TIMEOUT + 1); seg(1, 5); seg(0, 5); seg(1, 5);

    // Clock stops low.
    seg(0, 5); seg(1, 5); seg(0, 5);
    idle(80);
    seg(1, 4); seg(0, 4); seg(1, 4); seg(0, 4); seg(1, 4);

    // Randomized widths, occasionally near the timeout.
    for (int i = 0; i < 60; i++) begin
      int unsigned w;
      w = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 3, TIMEOUT + 3)
                                      : $urandom_range(1, 20);
      seg(logic'(i % 2), w);
    end

    // Reset in the middle of a low phase, then re-arm and measure again.
    seg(0, 5); seg(1, 6); seg(0, 3);
    apply_reset(1'b0);
    idle(10);
    seg(1, 5); seg(0, 5); seg(1, 4); seg(0, 4); seg(1, 4); seg(0, 4); seg(1, 4);
    idle(5);

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/clock_monitor.md
Name: clock_monitor

Overview:
- Receive-side companion to the team's clock divider.
- Samples an external, asynchronous slow clock `clkin` with the master clock.
- Measures its high time, low time and full period in master-clock cycles.
- Reports each completed measurement with a one-cycle strobe, flags loss of clock after a timeout, and indicates lock when consecutive periods agree.

Parameters:
- LEN, 26: width of the half-period counters and half-period outputs.
- TIMEOUT, 50000000: cycles without a `clkin` edge before `lost` asserts. Must satisfy TIMEOUT < 2^LEN.
- TOL, 2: maximum absolute difference between consecutive periods, in cycles, to count as matching.
- SYNC, 2: number of synchronizer flops on `clkin`. Minimum 2.

Ports:
- clk, input, 1: master clock.
- rst, input, 1: reset, asynchronous, active-low.
- clkin, input, 1: external clock under measurement, asynchronous to `clk`.
- half_hi, output, LEN: last measured high time, in cycles.
- half_lo, output, LEN: last measured low time, in cycles.
- period, output, LEN+1: half_hi + half_lo of the last completed period.
- valid, output, 1: one-cycle strobe; the three measurement outputs updated this cycle.
- locked, output, 1: the last two consecutive periods differ by at most TOL.
- lost, output, 1: no `clkin` edge for TIMEOUT cycles.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, synchronizer flops 0, counter 0, state SEARCH, arm flag 0.
- Synchronizer and edge detect:
  - `clkin` passes through SYNC flops, then one more flop for edge detect.
  - A rising or falling edge is seen SYNC+1 clk cycles after the input transition.
- Counter `ctr`:
  - Cleared to 0 on the cycle an edge is detected; otherwise increments by 1.
  - The half-period captured at an edge is ctr+1, i.e. clk cycles between consecutive detected edges.
- States:
  - SEARCH: the arm flag sets when a synchronized low is seen. A rising edge with arm set goes to MEAS_HI. A rising edge without arm is ignored, so no spurious edge when `clkin` is high at reset release.
  - MEAS_HI: falling edge captures ctr+1 into an internal hi register, then goes to MEAS_LO.
  - MEAS_LO, on rising edge, in the same cycle:
    - half_lo ← ctr+1.
    - half_hi ← the internal hi register.
    - period ← hi + ctr+1, zero-extended to LEN+1 bits.
    - valid=1 for exactly one cycle.
    - Next state MEAS_HI.
  - Timeout: in MEAS_HI or MEAS_LO, if ctr reaches TIMEOUT-1 with no edge, go to LOST. `lost` is set the next cycle and locked cleared. `ctr` holds at TIMEOUT-1 (no wrap).
  - LOST: on a falling edge, set arm. On a rising edge with arm set, clear `lost` and go to MEAS_HI. The first period after recovery is reported normally.
  - SEARCH: also times out to LOST, so `lost` asserts if `clkin` never toggles after reset.
- Lock:
  - On each valid, compare the new period against the previous one (held internally).
  - |new-prev| ≤ TOL → locked=1; otherwise locked=0.
  - The first valid after reset or LOST only loads prev; locked stays 0.
  - Lock therefore requires two valid strobes.
- Simultaneous events: an edge and ctr==TIMEOUT-1 in the same cycle → the edge wins (measurement taken, no LOST).
- Output stability: outputs hold between valid strobes. half_hi, half_lo and period keep their last values while in LOST.
- Glitches: pulses on `clkin` shorter than one clk cycle may be missed. Measured widths are quantized to ±1 cycle.

Test Plan:
- Power-up with clkin held high → no valid, state waits. After TIMEOUT cycles `lost`=1. Then a clkin low/high edge pair: `lost` clears on the rising edge, and valid follows after one full period.
- Square wave, 5 cycles high / 5 low, phase-aligned to clk → valid every 10 cycles with half_hi=5, half_lo=5, period=10. locked=0 after the first valid and 1 after the second.
- Duty 3 high / 7 low → half_hi=3, half_lo=7, period=10, locked=1 from the second valid.
- TIMEOUT=64, TOL=2: periods 10, 12, 16 → locked 0, 1, 0. Then stop clkin low → `lost`=1 exactly 64 cycles after the last edge is detected, and locked=0.
- Edge arriving exactly when ctr=TIMEOUT-1 → valid or a state advance occurs, and `lost` stays 0.
- Assert rst mid-MEAS_LO → all outputs 0 asynchronously. After release, a re-arm plus one full period is required before the next valid.
